instr_fetch_unit: RTL and testbench

Fetch stage directly upstream of the control sequencer's ID state. Accepts the level fetch request (instrfetch) and the current PC, performs one instruction-memory read over a valid/ready handshake, and latches the 32-bit instruction. It returns a one-cycle instr_fetched pulse and raises a sticky halt when it fetches a halting instruction or detects a fetch fault.

---
 rtl/rv32i_pkg.sv | 32 +++
 rtl/fetch_addr_check.sv | 26 ++
 rtl/instr_fetch_unit.sv | 176 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: fetch FSM states, the instruction
// encodings the fetch stage reacts to, and fetch fault codes.
package rv32i_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_RELEASE,
        S_HALTED
    } fetch_state_e;

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] ECALL     = 32'h0000_0073;
    localparam logic [31:0] EBREAK    = 32'h0010_0073;
    localparam logic [6:0]  OPC_FENCE = 7'b0001111;

    localparam logic [1:0] FLT_NONE     = 2'b00;
    localparam logic [1:0] FLT_MISALIGN = 2'b01;
    localparam logic [1:0] FLT_RANGE    = 2'b10;
    localparam logic [1:0] FLT_TIMEOUT  = 2'b11;

    localparam logic [31:0] IMEM_BASE_DEFAULT = 32'h0100_0000;

    // Instructions that stop the core: ECALL, EBREAK and any FENCE variant.
    function automatic logic is_halt_instr(input logic [31:0] i);
        return (i == ECALL) || (i == EBREAK) || (i[6:0] == OPC_FENCE);
    endfunction

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational address qualification for a word-addressed memory window:
// alignment, window bounds and the word index inside the window.
// Shared between the instruction fetch path and the data-memory path.
module fetch_addr_check
    import rv32i_pkg::*;
#(
    parameter logic [31:0] IMEM_BASE  = IMEM_BASE_DEFAULT,
    parameter int          IMEM_WORDS = 512
) (
    input  logic [31:0]                   pc,
    output logic                          misaligned,
    output logic                          out_of_range,
    output logic [$clog2(IMEM_WORDS)-1:0] word_index
);

    localparam int AW = $clog2(IMEM_WORDS);

    // 33-bit upper bound so BASE + size can never wrap past 2^32.
    localparam logic [32:0] LIMIT = {1'b0, IMEM_BASE} + (33'(IMEM_WORDS) * 33'd4);

    assign misaligned   = |pc[1:0];
    assign out_of_range = ({1'b0, pc} < {1'b0, IMEM_BASE}) || ({1'b0, pc} >= LIMIT);
    // Unsigned 32-bit offset; only meaningful when out_of_range is low.
    assign word_index   = AW'((pc - IMEM_BASE) >> 2);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: qualifies the PC, performs one instruction-memory
// read over a req/gnt + rvalid handshake, latches the instruction, pulses
// instr_fetched and raises a sticky halt on halting instructions or faults.
// Optional build macro: FETCH_TIMEOUT_EN adds a read timeout (fault 2'b11).
module instr_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] IMEM_BASE  = IMEM_BASE_DEFAULT,
    parameter int          IMEM_WORDS = 512,
    parameter int          RD_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          instrfetch,
    input  logic [31:0]                   pc,
    output logic                          imem_req,
    output logic [$clog2(IMEM_WORDS)-1:0] imem_addr,
    input  logic                          imem_gnt,
    input  logic                          imem_rvalid,
    input  logic [31:0]                   imem_rdata,
    output logic [31:0]                   instr,
    output logic                          instr_fetched,
    output logic [1:0]                    fetch_fault,
    output logic                          halt
);

    localparam int AW = $clog2(IMEM_WORDS);

    fetch_state_e  state, state_nxt;
    logic [31:0]   pc_q;
    logic [31:0]   instr_q;
    logic [AW-1:0] addr_q;
    logic [1:0]    fault_q;
    logic          halt_q;

    logic          misaligned, out_of_range;
    logic [AW-1:0] word_index;

    logic          load_pc, load_addr, capture, set_halt;
    logic [1:0]    fault_set;
    logic          tmo_hit;

    fetch_addr_check #(
        .IMEM_BASE  (IMEM_BASE),
        .IMEM_WORDS (IMEM_WORDS)
    ) u_addr_check (
        .pc           (pc_q),
        .misaligned   (misaligned),
        .out_of_range (out_of_range),
        .word_index   (word_index)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(RD_TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    // Read timeout counter: cleared on REQ entry, counts every REQ/WAIT cycle.
    always_ff @(posedge clk) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else if (load_addr)
            tmo_cnt <= '0;
        else if (state == S_REQ || state == S_WAIT)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Last waiting cycle: the counter reaches RD_TIMEOUT on the next edge.
    assign tmo_hit = (tmo_cnt == TW'(RD_TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        state_nxt     = state;
        imem_req      = 1'b0;
        instr_fetched = 1'b0;
        load_pc       = 1'b0;
        load_addr     = 1'b0;
        capture       = 1'b0;
        set_halt      = 1'b0;
        fault_set     = FLT_NONE;
        unique case (state)
            S_IDLE: begin
                if (instrfetch && !halt_q) begin
                    load_pc   = 1'b1;
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (misaligned) begin
                    fault_set = FLT_MISALIGN;
                    state_nxt = S_HALTED;
                end else if (out_of_range) begin
                    fault_set = FLT_RANGE;
                    state_nxt = S_HALTED;
                end else begin
                    load_addr = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_gnt && imem_rvalid) begin
                    capture   = 1'b1;
                    state_nxt = S_DONE;
                end else if (imem_gnt) begin
                    state_nxt = S_WAIT;
                end else if (tmo_hit) begin
                    fault_set = FLT_TIMEOUT;
                    state_nxt = S_HALTED;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    capture   = 1'b1;
                    state_nxt = S_DONE;
                end else if (tmo_hit) begin
                    fault_set = FLT_TIMEOUT;
                    state_nxt = S_HALTED;
                end
            end
            S_DONE: begin
                instr_fetched = 1'b1;
                set_halt      = is_halt_instr(instr_q);
                state_nxt     = S_RELEASE;
            end
            S_RELEASE: begin
                if (!instrfetch)
                    state_nxt = S_IDLE;
            end
            S_HALTED: state_nxt = S_HALTED;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers: fetch address, instruction latch, sticky fault/halt.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            pc_q    <= IMEM_BASE;
            instr_q <= NOP;
            addr_q  <= '0;
            fault_q <= FLT_NONE;
            halt_q  <= 1'b0;
        end else begin
            if (load_pc)
                pc_q <= pc;
            if (load_addr)
                addr_q <= word_index;
            if (capture)
                instr_q <= imem_rdata;
            if (fault_set != FLT_NONE) begin
                fault_q <= fault_set;
                halt_q  <= 1'b1;
            end
            if (set_halt)
                halt_q <= 1'b1;
        end
    end

    assign imem_addr   = addr_q;
    assign instr       = instr_q;
    assign fetch_fault = fault_q;
    assign halt        = halt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed and randomized fetches
// against a behavioural model of address qualification, latency and halting.
module tb_instr_fetch_unit;

    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam int          WORDS = 512;
    localparam int          TMO   = 16;
    localparam int          AW    = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          instrfetch;
    logic [31:0]   pc;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic [31:0]   instr;
    logic          instr_fetched;
    logic [1:0]    fetch_fault;
    logic          halt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .IMEM_BASE  (BASE),
        .IMEM_WORDS (WORDS),
        .RD_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instrfetch    (instrfetch),
        .pc            (pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_fetched (instr_fetched),
        .fetch_fault   (fetch_fault),
        .halt          (halt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: fault code from the address rules.
    function automatic logic [1:0] model_fault(input logic [31:0] a);
        logic [63:0] lim;
        lim = 64'(BASE) + 64'(4 * WORDS);
        if (a % 4 != 0)
            return 2'd1;
        if (a < BASE || 64'(a) >= lim)
            return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic model_halting(input logic [31:0] d);
        logic [6:0] opc;
        opc = d[6:0];
        return (d == 32'h0000_0073) || (d == 32'h0010_0073) || (opc == 7'b0001111);
    endfunction

    task automatic do_reset();
        rst_n       = 1'b0;
        instrfetch  = 1'b0;
        pc          = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        repeat (2) @(negedge clk);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_fetched", 32'(instr_fetched), 32'd0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One fetch: gd = request cycles refused before grant, rl = cycles from
    // grant to rvalid (0 = same cycle), hold = cycles instrfetch stays high
    // after the pulse. Called on a negative edge.
    task automatic fetch(input string tag, input logic [31:0] a_pc, input logic [31:0] data,
                         input int gd, input int rl, input int hold);
        logic [1:0]  ef;
        logic [31:0] ea;
        int          req_cnt, gnt_k, pulse_k, pulses, halt_k, rv_done;
        logic [AW-1:0] seen_addr;
        ef = model_fault(a_pc);
        ea = (a_pc - BASE) / 4;
        req_cnt = 0; gnt_k = -1; pulse_k = -1; pulses = 0; halt_k = -1; rv_done = 0;
        seen_addr = '0;
        instrfetch = 1'b1;
        pc = a_pc;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (instr_fetched) begin
                pulses++;
                if (pulse_k < 0) pulse_k = k;
            end
            if (halt && halt_k < 0) halt_k = k;
            if (imem_req) begin
                req_cnt++;
                seen_addr = imem_addr;
            end
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (imem_req && gnt_k < 0 && req_cnt == gd + 1) begin
                imem_gnt = 1'b1;
                gnt_k    = k;
            end
            if (gnt_k >= 0 && rv_done == 0 && k == gnt_k + rl) begin
                imem_rvalid = 1'b1;
                imem_rdata  = data;
                rv_done     = 1;
            end
            instrfetch = (pulse_k < 0 || k < pulse_k + hold);
            if (ef != 2'd0 && k >= 6) break;
            if (pulse_k >= 0 && k >= pulse_k + hold + 3) break;
        end
        instrfetch = 1'b0;
        if (ef != 2'd0) begin
            chk({tag, "_fault"}, 32'(fetch_fault), 32'(ef));
            chk({tag, "_halt"}, 32'(halt), 32'd1);
            chk({tag, "_halt_cycle"}, 32'(halt_k), 32'd2);
            chk({tag, "_no_req"}, 32'(req_cnt), 32'd0);
            chk({tag, "_no_pulse"}, 32'(pulses), 32'd0);
        end else begin
            chk({tag, "_pulses"}, 32'(pulses), 32'd1);
            chk({tag, "_latency"}, 32'(pulse_k), 32'(3 + gd + rl));
            chk({tag, "_req_cycles"}, 32'(req_cnt), 32'(gd + 1));
            chk({tag, "_addr"}, 32'(seen_addr), ea);
            chk({tag, "_instr"}, instr, data);
            chk({tag, "_fault"}, 32'(fetch_fault), 32'd0);
            chk({tag, "_halt"}, 32'(halt), 32'(model_halting(data)));
            chk({tag, "_halt_cycle"}, 32'(halt_k),
                model_halting(data) ? 32'(pulse_k + 1) : 32'hffff_ffff);
        end
    endtask

    initial begin
        int n_req, n_pulse, f_k, req17, req18;
        logic [31:0] rpc, rdat;
        int mode;

        // Reset and directed fetches.
        do_reset();
        fetch("zero_wait", 32'h0100_0008, 32'h0030_0093, 0, 1, 0);
        fetch("wait_states", 32'h0100_0010, 32'h0041_0113, 3, 2, 3);
        fetch("same_cycle", 32'h0100_0020, 32'h00a0_0193, 1, 0, 1);
        fetch("last_word", 32'h0100_07fc, 32'h1234_5013, 0, 1, 0);
        fetch("first_word", 32'h0100_0000, 32'h0050_0213, 2, 3, 0);

        do_reset();
        fetch("misaligned", 32'h0100_0006, 32'h0, 0, 1, 0);
        do_reset();
        fetch("above_range", 32'h0100_0800, 32'h0, 0, 1, 0);
        do_reset();
        fetch("below_range", 32'h00ff_fffc, 32'h0, 0, 1, 0);

        // ECALL halts; a later request must not reach memory.
        do_reset();
        fetch("ecall", 32'h0100_0040, 32'h0000_0073, 0, 1, 0);
        instrfetch = 1'b1;
        pc = 32'h0100_0044;
        n_req = 0; n_pulse = 0;
        repeat (10) begin
            @(negedge clk);
            if (imem_req) n_req++;
            if (instr_fetched) n_pulse++;
        end
        instrfetch = 1'b0;
        chk("halted_no_req", 32'(n_req), 32'd0);
        chk("halted_no_pulse", 32'(n_pulse), 32'd0);

        do_reset();
        fetch("ebreak", 32'h0100_0048, 32'h0010_0073, 1, 1, 0);
        do_reset();
        fetch("fence", 32'h0100_004c, 32'h0ff0_000f, 0, 2, 1);

        // Reset while waiting for rvalid, then a late rvalid.
        do_reset();
        instrfetch = 1'b1;
        pc = 32'h0100_0010;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            imem_gnt = (k == 2);
        end
        rst_n = 1'b0;
        instrfetch = 1'b0;
        imem_gnt = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hdead_beef;
        n_pulse = 0;
        @(negedge clk);
        imem_rvalid = 1'b0;
        if (instr_fetched) n_pulse++;
        repeat (3) begin
            @(negedge clk);
            if (instr_fetched) n_pulse++;
        end
        chk("late_rv_pulse", 32'(n_pulse), 32'd0);
        chk("late_rv_instr", instr, 32'h0000_0013);
        chk("late_rv_req", 32'(imem_req), 32'd0);
        chk("late_rv_addr", 32'(imem_addr), 32'd0);
        chk("late_rv_halt", 32'(halt), 32'd0);
        chk("late_rv_fault", 32'(fetch_fault), 32'd0);

        // Memory that never grants.
        do_reset();
        instrfetch = 1'b1;
        pc = 32'h0100_0020;
        f_k = -1; req17 = 0; req18 = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (fetch_fault == 2'b11 && f_k < 0) f_k = k;
            if (k == 17) req17 = int'(imem_req);
            if (k == 18) req18 = int'(imem_req);
        end
        instrfetch = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        chk("timeout_cycle", 32'(f_k), 32'(2 + TMO));
        chk("timeout_req_before", 32'(req17), 32'd1);
        chk("timeout_req_drop", 32'(req18), 32'd0);
        chk("timeout_halt", 32'(halt), 32'd1);
`else
        chk("no_timeout_fault", 32'(fetch_fault), 32'd0);
        chk("no_timeout_halt", 32'(halt), 32'd0);
        chk("no_timeout_req", 32'(imem_req), 32'd1);
        chk("no_timeout_req18", 32'(req18), 32'd1);
`endif

        // Randomized fetches.
        for (int i = 0; i < 12; i++) begin
            do_reset();
            mode = $urandom_range(0, 9);
            rpc  = BASE + ($urandom_range(0, WORDS - 1) << 2);
            rdat = $urandom;
            if (mode == 0)
                rpc = rpc + $urandom_range(1, 3);
            else if (mode == 1)
                rpc = ($urandom_range(0, 1) == 1) ? BASE + 32'h800 + ($urandom_range(0, 255) << 2)
                                                  : BASE - (($urandom_range(0, 255) + 1) << 2);
            else if (mode == 2)
                rdat = 32'h0000_0073;
            fetch($sformatf("rand%0d", i), rpc, rdat,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
